// File: rtl/mdl_memory_2p.sv
// Simple dual-port register array: one synchronous write port and one registered
// read port with independent addresses, fully cleared by synchronous reset.
module mdl_memory_2p #(
  parameter int PKT_NUM = 7,
  parameter int DATA_SZ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_in,
  input  logic [$clog2(PKT_NUM)-1:0] wr_addr,
  input  logic [DATA_SZ-1:0]         data_in,
  input  logic                       vld_out,
  input  logic [$clog2(PKT_NUM)-1:0] rd_addr,
  output logic [DATA_SZ-1:0]         data_out
);

  localparam int ADDR_W = $clog2(PKT_NUM);
  // One extra bit so the depth itself is representable when PKT_NUM is a power of two.
  localparam logic [ADDR_W:0] DEPTH_L = PKT_NUM[ADDR_W:0];

  logic [DATA_SZ-1:0] mem_r [PKT_NUM];
  logic [DATA_SZ-1:0] data_out_r;
  logic               wr_ok_s;
  logic               rd_ok_s;

  // Address range decode for both ports.
  always_comb begin
    wr_ok_s = 1'b0;
    rd_ok_s = 1'b0;
    if ({1'b0, wr_addr} < DEPTH_L) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
    if ({1'b0, rd_addr} < DEPTH_L) begin
      rd_ok_s = 1'b1;
    end else begin
      rd_ok_s = 1'b0;
    end
  end

  // Storage array: reset clears every entry, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PKT_NUM; i++) begin
        mem_r[i] <= {DATA_SZ{1'b0}};
      end
    end else if (vld_in && wr_ok_s) begin
      mem_r[wr_addr] <= data_in;
    end
  end

  // Registered read port; sees pre-write contents, so collisions are read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= {DATA_SZ{1'b0}};
    end else if (vld_out) begin
      if (rd_ok_s) begin
        data_out_r <= mem_r[rd_addr];
      end else begin
        data_out_r <= {DATA_SZ{1'b0}};
      end
    end
  end

  assign data_out = data_out_r;

endmodule

// File: tb/tb_mdl_memory_2p.sv
// Scoreboard bench for mdl_memory_2p: a reference array predicts data_out per cycle.
module tb_mdl_memory_2p;

  localparam int PKT_NUM = 7;
  localparam int DATA_SZ = 3;
  localparam int ADDR_W  = $clog2(PKT_NUM);

  logic               clk;
  logic               rst;
  logic               vld_in;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_SZ-1:0] data_in;
  logic               vld_out;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_SZ-1:0] data_out;

  logic [DATA_SZ-1:0] model_mem [PKT_NUM];
  logic [DATA_SZ-1:0] model_out;
  logic [DATA_SZ-1:0] exp_q [$];
  int                 n_vec;
  int                 n_err;

  mdl_memory_2p #(.PKT_NUM(PKT_NUM), .DATA_SZ(DATA_SZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .vld_out  (vld_out),
    .rd_addr  (rd_addr),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DATA_SZ-1:0] got,
                           input logic [DATA_SZ-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: data_out=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict data_out after the edge, then compare.
  task automatic cycle(input string tag, input logic r, input logic vi,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_SZ-1:0] di,
                       input logic vo, input logic [ADDR_W-1:0] ra);
    logic [DATA_SZ-1:0] exp;
    @(negedge clk);
    rst = r; vld_in = vi; wr_addr = wa; data_in = di; vld_out = vo; rd_addr = ra;
    if (r) begin
      for (int i = 0; i < PKT_NUM; i++) model_mem[i] = 3'd0;
      model_out = 3'd0;
    end else begin
      if (vo) model_out = (int'(ra) < PKT_NUM) ? model_mem[ra] : 3'd0;
      if (vi && int'(wa) < PKT_NUM) model_mem[wa] = di;
    end
    exp_q.push_back(model_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_val(tag, data_out, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; model_out = 3'd0;
    for (int i = 0; i < PKT_NUM; i++) model_mem[i] = 3'd0;
    rst = 1'b1; vld_in = 1'b0; wr_addr = 3'd0; data_in = 3'd0; vld_out = 1'b0; rd_addr = 3'd0;

    cycle("reset0", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    cycle("reset1", 1'b1, 1'b1, 3'd1, 3'd7, 1'b1, 3'd1);

    // Reset clears a previously written entry.
    cycle("wr2", 1'b0, 1'b1, 3'd2, 3'd5, 1'b0, 3'd0);
    cycle("rst_mid", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    cycle("rd2_after_rst", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2);

    // Basic latency.
    cycle("wr4", 1'b0, 1'b1, 3'd4, 3'd6, 1'b0, 3'd0);
    cycle("rd4", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4);

    // Fill and read back.
    for (int i = 0; i < PKT_NUM; i++)
      cycle("fill", 1'b0, 1'b1, 3'(i), 3'(i + 1), 1'b0, 3'd0);
    for (int i = 0; i < PKT_NUM; i++)
      cycle("fill_rd", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'(i));
    cycle("ovw0", 1'b0, 1'b1, 3'd0, 3'd3, 1'b0, 3'd0);
    cycle("rd0", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0);

    // Read-during-write collision.
    cycle("wr3", 1'b0, 1'b1, 3'd3, 3'd2, 1'b0, 3'd0);
    cycle("collide", 1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 3'd3);
    cycle("rd3_new", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3);

    // Read hold and write-enable gating.
    cycle("wr1", 1'b0, 1'b1, 3'd1, 3'd4, 1'b0, 3'd0);
    cycle("rd1", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++)
      cycle("hold", 1'b0, 1'b0, 3'd5, (i % 2 == 0) ? 3'd1 : 3'd2, 1'b0, 3'd5);
    cycle("rd5_unchanged", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd5);

    // Out-of-range accesses.
    cycle("wr7_oor", 1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 3'd0);
    cycle("rd7_oor", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd7);
    for (int i = 0; i < PKT_NUM; i++)
      cycle("oor_scan", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'(i));

    // Random traffic with occasional reset.
    for (int i = 0; i < 60; i++)
      cycle("rand", ($urandom_range(0, 29) == 0), 1'($urandom), 3'($urandom),
            3'($urandom), 1'($urandom), 3'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
